// File: rtl/store_stream_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_stream_checker_pkg
// Description : Shared types and constants for the store stream checker:
//               checker FSM state encoding and expected-store entry width.
// Revision    : 1.0 - initial release
// ============================================================================
package store_stream_checker_pkg;

    // One expected-store entry is {address[31:0], data[31:0]}.
    localparam int unsigned ENTRY_W = 64;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_e;

endpackage : store_stream_checker_pkg
`default_nettype wire

// File: rtl/store_stream_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : store_stream_checker_if
// Description : Bundle between a data-memory write port and the store checker.
//               Store side : MemWrite, DataAdr, WriteData (driven by master).
//               Status side: pass_count, exp_idx, done, passed, failed,
//                            fail_adr, fail_data (driven by the checker).
// Revision    : 1.0 - initial release
// ============================================================================
interface store_stream_checker_if;

    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;

    logic [7:0]  pass_count;
    logic [7:0]  exp_idx;
    logic        done;
    logic        passed;
    logic        failed;
    logic [31:0] fail_adr;
    logic [31:0] fail_data;

    // Store source (CPU write port / stimulus), observes status.
    modport master (
        output MemWrite, DataAdr, WriteData,
        input  pass_count, exp_idx, done, passed, failed, fail_adr, fail_data
    );

    // Checker: consumes stores, produces status.
    modport slave (
        input  MemWrite, DataAdr, WriteData,
        output pass_count, exp_idx, done, passed, failed, fail_adr, fail_data
    );

endinterface : store_stream_checker_if
`default_nettype wire

// File: rtl/store_stream_checker_rom.sv
`default_nettype none
// ============================================================================
// Module      : store_stream_checker_rom
// Description : Synchronous-read expected-store ROM. Contents come from the
//               packed TABLE parameter (entry i at bits [i*64 +: 64]).
//               Addresses at or beyond DEPTH read back as zero.
// Ports       : clk     - clock
//               addr_i  - entry index (8 bits)
//               data_o  - registered {adr,data} entry
// Revision    : 1.0 - initial release
// ============================================================================
module store_stream_checker_rom
    import store_stream_checker_pkg::*;
#(
    parameter int unsigned                  DEPTH = 37,
    parameter logic [DEPTH*ENTRY_W-1:0]     TABLE = '0
) (
    input  wire logic               clk,
    input  wire logic [7:0]         addr_i,
    output      logic [ENTRY_W-1:0] data_o
);

    // Full 256-entry view so the 8-bit address indexes it without truncation.
    logic [ENTRY_W-1:0] w_mem [256];
    logic [ENTRY_W-1:0] data_q;

    for (genvar gi = 0; gi < 256; gi++) begin : g_rom
        if (gi < DEPTH) begin : g_valid
            assign w_mem[gi] = TABLE[gi*ENTRY_W +: ENTRY_W];
        end else begin : g_pad
            assign w_mem[gi] = '0;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= w_mem[addr_i];
    end

    assign data_o = data_q;

endmodule : store_stream_checker_rom
`default_nettype wire

// File: rtl/store_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : store_stream_checker
// Description : In-order checker for the data-memory write port. Stores are
//               registered (stage 1), then compared against the expected
//               table (stage 2). Reports in-order match count, next index,
//               and sticky pass/fail status with the offending store.
// Ports       : clk    - clock, rising edge
//               reset  - synchronous, active-high
//               bus    - store inputs / status outputs (slave modport)
// Revision    : 1.0 - initial release
// ============================================================================
module store_stream_checker
    import store_stream_checker_pkg::*;
#(
    parameter int unsigned                  NUM_EXP   = 37,
    parameter logic [NUM_EXP*ENTRY_W-1:0]   EXP_TABLE = '0,
    parameter logic [31:0]                  IGN_LO    = 32'd96,
    parameter logic [31:0]                  IGN_HI    = 32'd99,
    parameter logic [31:0]                  END_ADR   = 32'd40,
    parameter logic [31:0]                  END_DATA  = 32'd30
) (
    input  wire logic              clk,
    input  wire logic              reset,
    store_stream_checker_if.slave  bus
);

    localparam logic [7:0] NUM_EXP_C = 8'(NUM_EXP);

    state_e       state_q, state_d;
    logic         cap_v_q;
    logic [31:0]  cap_adr_q, cap_dat_q;
    logic [7:0]   pass_count_q, pass_count_d;
    logic [7:0]   exp_idx_q, exp_idx_d;
    logic         passed_q, passed_d;
    logic         failed_q, failed_d;
    logic         done_q, done_d;
    logic [31:0]  fail_adr_q, fail_adr_d;
    logic [31:0]  fail_dat_q, fail_dat_d;

    logic [ENTRY_W-1:0] w_rom_data;
    logic [7:0]         w_rom_addr;
    logic               w_ignore;
    logic               w_is_end;

    // ROM is addressed with the next index so rom output always matches
    // exp_idx_q at evaluation time; back-to-back stores need no bubble.
    assign w_rom_addr = reset ? 8'd0 : exp_idx_d;

    store_stream_checker_rom #(
        .DEPTH (NUM_EXP),
        .TABLE (EXP_TABLE)
    ) u_rom (
        .clk    (clk),
        .addr_i (w_rom_addr),
        .data_o (w_rom_data)
    );

    assign w_ignore = (cap_adr_q >= IGN_LO) && (cap_adr_q <= IGN_HI);
    assign w_is_end = (cap_adr_q == END_ADR) && (cap_dat_q == END_DATA);

    always_comb begin
        logic w_fail;
        w_fail       = 1'b0;
        state_d      = state_q;
        pass_count_d = pass_count_q;
        exp_idx_d    = exp_idx_q;
        passed_d     = passed_q;
        failed_d     = failed_q;
        fail_adr_d   = fail_adr_q;
        fail_dat_d   = fail_dat_q;

        if (state_q == ST_RUN && cap_v_q) begin
            if (w_ignore) begin
                // Scratch window: never checked, takes precedence over all rules.
            end else if (w_is_end) begin
                if (exp_idx_q == NUM_EXP_C) begin
                    state_d  = ST_PASS;
                    passed_d = 1'b1;
                end else begin
                    w_fail = 1'b1;          // terminal store arrived early
                end
            end else if (exp_idx_q == NUM_EXP_C) begin
                w_fail = 1'b1;              // store beyond end of table
            end else if ({cap_adr_q, cap_dat_q} == w_rom_data) begin
                pass_count_d = pass_count_q + 8'd1;
                exp_idx_d    = exp_idx_q + 8'd1;
            end else begin
                w_fail = 1'b1;
            end
        end

        if (w_fail) begin
            state_d    = ST_FAIL;
            failed_d   = 1'b1;
            fail_adr_d = cap_adr_q;
            fail_dat_d = cap_dat_q;
        end

        done_d = passed_d | failed_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            cap_v_q      <= 1'b0;
            cap_adr_q    <= '0;
            cap_dat_q    <= '0;
            pass_count_q <= '0;
            exp_idx_q    <= '0;
            passed_q     <= 1'b0;
            failed_q     <= 1'b0;
            done_q       <= 1'b0;
            fail_adr_q   <= '0;
            fail_dat_q   <= '0;
        end else begin
            state_q      <= state_d;
            cap_v_q      <= bus.MemWrite;
            cap_adr_q    <= bus.DataAdr;
            cap_dat_q    <= bus.WriteData;
            pass_count_q <= pass_count_d;
            exp_idx_q    <= exp_idx_d;
            passed_q     <= passed_d;
            failed_q     <= failed_d;
            done_q       <= done_d;
            fail_adr_q   <= fail_adr_d;
            fail_dat_q   <= fail_dat_d;
        end
    end

    assign bus.pass_count = pass_count_q;
    assign bus.exp_idx    = exp_idx_q;
    assign bus.done       = done_q;
    assign bus.passed     = passed_q;
    assign bus.failed     = failed_q;
    assign bus.fail_adr   = fail_adr_q;
    assign bus.fail_data  = fail_dat_q;

endmodule : store_stream_checker
`default_nettype wire

// File: tb/tb_store_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_stream_checker
// Description : Directed self-checking bench. Instance A uses a 3-entry table
//               {100,25},{104,4096},{108,4184}; instance B uses a 37-entry
//               table {0x200+4i, 3i+7}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_stream_checker;

    localparam int NB = 37;

    function automatic logic [NB*64-1:0] mk_tab();
        logic [NB*64-1:0] t;
        t = '0;
        for (int i = 0; i < NB; i++) begin
            t[i*64 +: 64] = {32'h200 + 32'(4*i), 32'(3*i + 7)};
        end
        return t;
    endfunction

    localparam logic [3*64-1:0] TAB_A = {32'd108, 32'd4184,
                                         32'd104, 32'd4096,
                                         32'd100, 32'd25};
    localparam logic [NB*64-1:0] TAB_B = mk_tab();

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    store_stream_checker_if busa ();
    store_stream_checker_if busb ();

    store_stream_checker #(
        .NUM_EXP   (3),
        .EXP_TABLE (TAB_A)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (busa)
    );

    store_stream_checker #(
        .NUM_EXP   (NB),
        .EXP_TABLE (TAB_B)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (busb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic store(input bit sel, input logic [31:0] adr, input logic [31:0] dat);
        @(negedge clk);
        if (sel) begin
            busb.MemWrite = 1'b1; busb.DataAdr = adr; busb.WriteData = dat;
        end else begin
            busa.MemWrite = 1'b1; busa.DataAdr = adr; busa.WriteData = dat;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            busa.MemWrite = 1'b0;
            busb.MemWrite = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        busa.MemWrite = 1'b0;
        busb.MemWrite = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic full_a();
        store(0, 32'd100, 32'd25);
        store(0, 32'd104, 32'd4096);
        store(0, 32'd108, 32'd4184);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        busa.MemWrite = 1'b0; busa.DataAdr = '0; busa.WriteData = '0;
        busb.MemWrite = 1'b0; busb.DataAdr = '0; busb.WriteData = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_pass_count", 32'(busa.pass_count), 0);
        chk("rst_exp_idx",    32'(busa.exp_idx),    0);
        chk("rst_done",       32'(busa.done),       0);
        chk("rst_passed",     32'(busa.passed),     0);
        chk("rst_failed",     32'(busa.failed),     0);
        chk("rst_fail_adr",   busa.fail_adr,        0);

        // 1: full match then terminal store, back-to-back
        full_a();
        store(0, 32'd40, 32'd30);
        idle(1);
        chk("t1_not_yet_done", 32'(busa.done), 0);
        idle(1);
        chk("t1_passed",     32'(busa.passed),     1);
        chk("t1_done",       32'(busa.done),       1);
        chk("t1_failed",     32'(busa.failed),     0);
        chk("t1_pass_count", 32'(busa.pass_count), 3);
        chk("t1_exp_idx",    32'(busa.exp_idx),    3);
        // PASS is sticky: a later bad store changes nothing
        store(0, 32'd200, 32'd1);
        idle(2);
        chk("t1_sticky_passed", 32'(busa.passed), 1);
        chk("t1_sticky_failed", 32'(busa.failed), 0);

        // 2: data mismatch on the second store
        do_reset();
        store(0, 32'd100, 32'd25);
        store(0, 32'd104, 32'd4097);
        store(0, 32'd108, 32'd4184);
        store(0, 32'd40,  32'd30);
        idle(2);
        chk("t2_failed",     32'(busa.failed),     1);
        chk("t2_passed",     32'(busa.passed),     0);
        chk("t2_done",       32'(busa.done),       1);
        chk("t2_fail_adr",   busa.fail_adr,        104);
        chk("t2_fail_data",  busa.fail_data,       4097);
        chk("t2_pass_count", 32'(busa.pass_count), 1);
        chk("t2_exp_idx",    32'(busa.exp_idx),    1);

        // 3: scratch-window stores (96..99) interleaved are ignored
        do_reset();
        store(0, 32'd96,  32'd1);
        store(0, 32'd100, 32'd25);
        store(0, 32'd97,  32'd2);
        store(0, 32'd99,  32'd3);
        store(0, 32'd104, 32'd4096);
        store(0, 32'd98,  32'd5);
        store(0, 32'd108, 32'd4184);
        store(0, 32'd96,  32'd7);
        store(0, 32'd40,  32'd30);
        idle(2);
        chk("t3_passed",     32'(busa.passed),     1);
        chk("t3_failed",     32'(busa.failed),     0);
        chk("t3_pass_count", 32'(busa.pass_count), 3);

        // 3b: address just below the window is checked (and mismatches)
        do_reset();
        store(0, 32'd95, 32'd0);
        idle(2);
        chk("t3b_failed",   32'(busa.failed), 1);
        chk("t3b_fail_adr", busa.fail_adr,    95);

        // 4a: early terminal store
        do_reset();
        store(0, 32'd100, 32'd25);
        store(0, 32'd40,  32'd30);
        idle(2);
        chk("t4a_failed",     32'(busa.failed),     1);
        chk("t4a_passed",     32'(busa.passed),     0);
        chk("t4a_fail_adr",   busa.fail_adr,        40);
        chk("t4a_fail_data",  busa.fail_data,       30);
        chk("t4a_pass_count", 32'(busa.pass_count), 1);

        // 4b: overrun after all entries matched
        do_reset();
        full_a();
        store(0, 32'd200, 32'd1);
        idle(2);
        chk("t4b_failed",     32'(busa.failed),     1);
        chk("t4b_fail_adr",   busa.fail_adr,        200);
        chk("t4b_fail_data",  busa.fail_data,       1);
        chk("t4b_pass_count", 32'(busa.pass_count), 3);

        // 5: mid-run reset, store presented right at reset deassertion
        do_reset();
        store(0, 32'd100, 32'd25);
        store(0, 32'd104, 32'd4096);
        idle(2);
        chk("t5_mid_count", 32'(busa.pass_count), 2);
        @(negedge clk);
        reset = 1'b1;
        busa.MemWrite = 1'b0;
        @(negedge clk);
        chk("t5_rst_count", 32'(busa.pass_count), 0);
        chk("t5_rst_idx",   32'(busa.exp_idx),    0);
        reset = 1'b0;
        busa.MemWrite = 1'b1; busa.DataAdr = 32'd100; busa.WriteData = 32'd25;
        store(0, 32'd104, 32'd4096);
        store(0, 32'd108, 32'd4184);
        store(0, 32'd40,  32'd30);
        idle(2);
        chk("t5_passed",     32'(busa.passed),     1);
        chk("t5_pass_count", 32'(busa.pass_count), 3);

        // 6: 37-entry table with gaps, bounded wait for completion
        do_reset();
        for (int i = 0; i < NB; i++) begin
            store(1, 32'h200 + 32'(4*i), 32'(3*i + 7));
            if (i % 5 == 4) idle(1);
        end
        store(1, 32'd40, 32'd30);
        idle(1);
        for (int c = 0; c < 2000 && !busb.done; c++) @(negedge clk);
        chk("t6_done",       32'(busb.done),       1);
        chk("t6_passed",     32'(busb.passed),     1);
        chk("t6_failed",     32'(busb.failed),     0);
        chk("t6_pass_count", 32'(busb.pass_count), 37);
        chk("t6_exp_idx",    32'(busb.exp_idx),    37);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_store_stream_checker
`default_nettype wire
